chacha_stream_ctrl: RTL

Initiator-side controller for the ChaCha keystream core. Latches key/nonce/initial counter from the host, issues init/next block requests to the core, buffers each returned 512-bit keystream block, and XORs it word by word onto a 32-bit valid/ready data stream. It sits between the host stream interface and chacha_core and encrypts and decrypts identically.

---
 rtl/chacha_stream_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/chacha_stream_ctrl.sv
// Initiator-side controller for a ChaCha keystream core: requests 512-bit
// blocks, buffers them, and XORs them word by word onto a 32-bit stream.
module chacha_stream_ctrl #(
    parameter logic [4:0] ROUNDS = 5'd20,
    parameter logic       KEYLEN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_start,
    input  logic [255:0] cfg_key,
    input  logic [63:0]  cfg_nonce,
    input  logic [63:0]  cfg_ctr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         ctr_wrap,
    output logic         core_init,
    output logic         core_next,
    output logic         core_keylen,
    output logic [4:0]   core_rounds,
    output logic [255:0] core_key,
    output logic [63:0]  core_ctr,
    output logic [63:0]  core_iv,
    output logic [511:0] core_data_in,
    input  logic         core_ready,
    input  logic [511:0] core_data,
    input  logic         core_valid,
    output logic [1:0]   fsm_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    logic [1:0]   state;
    logic [255:0] key_q;
    logic [63:0]  nonce_q;
    logic [63:0]  ctr_q;
    logic [511:0] ks_buf;
    logic [3:0]   idx;
    logic         first;
    logic         accept;
    logic         issue;
    logic [31:0]  ks_word;

    // Handshakes: a word moves on any rising edge where valid && ready; a
    // producer holds valid and data stable until that edge, and ready may
    // depend combinationally on the consumer's state but never on valid.
    assign in_ready = (state == S_STREAM) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = (state == S_REQ) && core_ready;

    assign core_init    = issue && first;
    assign core_next    = issue && !first;
    assign core_keylen  = KEYLEN;
    assign core_rounds  = ROUNDS;
    assign core_key     = key_q;
    assign core_ctr     = ctr_q;
    assign core_iv      = nonce_q;
    assign core_data_in = '0;
    assign busy         = (state != S_IDLE);
    assign fsm_state    = state;

    // Word 0 sits in the top 32 bits of the block, so ~idx selects the slice.
    assign ks_word = ks_buf[{~idx, 5'b00000} +: 32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            key_q    <= '0;
            nonce_q  <= '0;
            ctr_q    <= '0;
            ks_buf   <= '0;
            idx      <= '0;
            first    <= 1'b1;
            ctr_wrap <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        key_q    <= cfg_key;
                        nonce_q  <= cfg_nonce;
                        ctr_q    <= cfg_ctr;
                        ctr_wrap <= 1'b0;
                        first    <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (core_ready) begin
                        first <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_valid) begin
                        ks_buf <= core_data;
                        idx    <= '0;
                        ctr_q  <= ctr_q + 64'd1;
                        if (&ctr_q) begin
                            ctr_wrap <= 1'b1;
                        end
                        state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        idx <= idx + 4'd1;
                        // A final word ends the message even on a block edge.
                        if (in_last) begin
                            state <= S_IDLE;
                        end else if (idx == 4'd15) begin
                            state <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ ks_word;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
